// File: rtl/serial_frame_tx_pkg.sv
// ---------------------------------------------------------------
// serial_frame_tx_pkg : frame state encoding and line levels, rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package serial_frame_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Line levels shared with the receiving detector FSMs.
  localparam logic START_LVL = 1'b1;
  localparam logic STOP_LVL  = 1'b0;
  localparam logic IDLE_LVL  = 1'b0;

  // Start, parity and stop bits added to every data word.
  localparam int FRAME_OVERHEAD = 3;

endpackage

`default_nettype wire

// File: rtl/serial_frame_tx_bit_timer.sv
// ---------------------------------------------------------------
// bit_timer : counts BIT_TICKS clocks per serial bit, rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module bit_timer #(
  parameter int BIT_TICKS = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  // With BIT_TICKS=1 the counter is held at 0 and tick stays high.
  localparam int CNT_W = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_TICKS - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

`default_nettype wire

// File: rtl/serial_frame_tx.sv
// ---------------------------------------------------------------
// serial_frame_tx : framed parallel-to-serial transmitter, rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int BIT_TICKS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             X,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [IDX_W-1:0] idx;
  logic             parity;
  logic             tick;

  // Timer held in reset while idle so START always gets a full bit period.
  bit_timer #(
    .BIT_TICKS (BIT_TICKS)
  ) u_bit_timer (
    .clk   (clk),
    .reset (reset),
    .clear (state == IDLE),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      shreg  <= '0;
      idx    <= '0;
      parity <= 1'b0;
      X      <= IDLE_LVL;
      ready  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          X <= IDLE_LVL;
          if (load && ready) begin
            shreg  <= data_in;
            parity <= ^data_in;
            idx    <= '0;
            state  <= START;
            X      <= START_LVL;
            ready  <= 1'b0;
            busy   <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            X     <= shreg[0];
            shreg <= shreg >> 1;
          end
        end
        DATA: begin
          if (tick) begin
            if (idx == LAST_IDX) begin
              state <= PARITY;
              X     <= parity;
            end else begin
              idx   <= idx + IDX_W'(1);
              X     <= shreg[0];
              shreg <= shreg >> 1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state <= STOP;
            X     <= STOP_LVL;
          end
        end
        STOP: begin
          if (tick) begin
            state <= IDLE;
            X     <= IDLE_LVL;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          X     <= IDLE_LVL;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
// ---------------------------------------------------------------
// tb_serial_frame_tx : three transmitters (BIT_TICKS 1..3) vs frame model, rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_serial_frame_tx;

  logic       clk;
  logic       rst_s [3];
  logic       ld_s  [3];
  logic [7:0] din_s [3];
  logic       rdy_s [3];
  logic       x_s   [3];
  logic       bsy_s [3];
  logic       dn_s  [3];

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    serial_frame_tx #(
      .WIDTH     (8),
      .BIT_TICKS (g + 1)
    ) u_dut (
      .clk     (clk),
      .reset   (rst_s[g]),
      .load    (ld_s[g]),
      .data_in (din_s[g]),
      .ready   (rdy_s[g]),
      .X       (x_s[g]),
      .busy    (bsy_s[g]),
      .done    (dn_s[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input int u, input string tag, input logic exp_done);
    check({tag, "_x"},     32'(x_s[u]),   0);
    check({tag, "_ready"}, 32'(rdy_s[u]), 1);
    check({tag, "_busy"},  32'(bsy_s[u]), 0);
    check({tag, "_done"},  32'(dn_s[u]),  32'(exp_done));
  endtask

  // Sends one word on unit u; returns in the done cycle (or idle after an abort).
  // inj: frame cycle at which a spurious load of 8'hFF is pulsed; rst_at: abort cycle.
  task automatic run_frame(input int u, input logic [7:0] w, input int inj, input int rst_at);
    int   bt;
    int   len;
    logic exp_q [$];
    logic obs [$];
    logic [7:0] rx;
    logic par;
    bt  = u + 1;
    len = 11 * bt;
    for (int k = 0; k < bt; k++) exp_q.push_back(1'b1);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < bt; k++) exp_q.push_back(w[i]);
    for (int k = 0; k < bt; k++) exp_q.push_back(($countones(w) % 2) == 1);
    for (int k = 0; k < bt; k++) exp_q.push_back(1'b0);

    din_s[u] = w;
    ld_s[u]  = 1'b1;
    step();
    ld_s[u]  = 1'b0;
    din_s[u] = 8'($urandom);

    for (int c = 0; c < len; c++) begin
      check("frame_x",     32'(x_s[u]),   32'(exp_q[c]));
      check("frame_busy",  32'(bsy_s[u]), 1);
      check("frame_ready", 32'(rdy_s[u]), 0);
      check("frame_done",  32'(dn_s[u]),  0);
      obs.push_back(x_s[u]);
      if (c == rst_at) begin
        ld_s[u]  = 1'b0;
        rst_s[u] = 1'b1;
        step();
        rst_s[u] = 1'b0;
        check_idle(u, "abort", 1'b0);
        for (int k = 0; k < len; k++) begin
          step();
          check("abort_no_done", 32'(dn_s[u]), 0);
          check("abort_x",       32'(x_s[u]),  0);
        end
        return;
      end
      ld_s[u] = (c == inj);
      if (c == inj) din_s[u] = 8'hFF;
      step();
    end
    ld_s[u] = 1'b0;
    check_idle(u, "end", 1'b1);

    // Receiver view: sample each data bit mid-period, then verify parity.
    for (int i = 0; i < 8; i++) rx[i] = obs[(1 + i) * bt + bt / 2];
    par = obs[9 * bt + bt / 2];
    check("loopback_word", 32'(rx), 32'(w));
    check("parity_even", 32'(($countones(rx) + int'(par)) % 2), 0);
  endtask

  initial begin
    int u;
    int gap;
    int len;
    for (int i = 0; i < 3; i++) begin
      rst_s[i] = 1'b1;
      ld_s[i]  = 1'b0;
      din_s[i] = 8'h00;
    end
    step();
    for (int i = 0; i < 3; i++) begin
      check_idle(i, "reset", 1'b0);
      rst_s[i] = 1'b0;
    end
    step();

    run_frame(1, 8'hA5, -1, -1);
    step();
    run_frame(0, 8'h07, -1, -1);
    step();
    run_frame(0, 8'h3C, 4, -1);
    run_frame(0, 8'h81, -1, -1);
    step();
    run_frame(2, 8'hA5, -1, 10);
    run_frame(2, 8'h5A, -1, -1);

    for (int n = 0; n < 30; n++) begin
      u   = int'($urandom_range(2, 0));
      len = 11 * (u + 1);
      gap = int'($urandom_range(3, 0));
      for (int k = 0; k < gap; k++) begin
        step();
        check_idle(u, "gap", 1'b0);
      end
      run_frame(u, 8'($urandom), int'($urandom_range(len + 5, 0)),
                ($urandom_range(4, 0) == 0) ? int'($urandom_range(len - 1, 0)) : -1);
    end

    step();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
